// File: rtl/game_flow_ctrl_pkg.sv
// game_pkg: shared definitions for the game session controller.
// Holds the state enumeration driven out on game_state, plus plain
// localparams for the three legacy codes so that comparisons elsewhere
// in top_vga can use them without importing the enum type.
package game_pkg;

    typedef enum logic [2:0] {
        MENU        = 3'd0,
        ACTIVE      = 3'd1,
        END         = 3'd2,
        PAUSED      = 3'd3,
        LEVEL_CLEAR = 3'd4
    } game_state_t;

    localparam logic [2:0] GS_MENU   = 3'd0;
    localparam logic [2:0] GS_ACTIVE = 3'd1;
    localparam logic [2:0] GS_END    = 3'd2;

endpackage

// File: rtl/game_flow_ctrl_edge_det.sv
// edge_det: registered single-signal edge detector.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset
//   sig_in   - level input, already synchronised to clk
//   edge_out - one-cycle pulse, registered, one cycle after the edge is sampled
// RISING=1 detects 0->1 transitions, RISING=0 detects 1->0 transitions.
module edge_det #(
    parameter bit RISING = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic edge_out
);

    logic sig_q;
    logic sig_d;
    logic pulse_q;
    logic pulse_d;

    // Compare the current input against last cycle's copy to find the edge.
    always_comb begin
        sig_d = sig_in;
        if (RISING) begin
            pulse_d = sig_in & ~sig_q;
        end else begin
            pulse_d = ~sig_in & sig_q;
        end
    end

    // History and pulse registers; the pulse itself is registered so that
    // downstream logic sees a clean flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sig_q   <= sig_d;
            pulse_q <= pulse_d;
        end
    end

    assign edge_out = pulse_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: sequences a whole play session - menu, NUM_LEVELS boss
// levels separated by a timed level-clear intermission, pause, and an end
// screen carrying the win/lose outcome.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   vsync           - frame sync; each rising edge is one frame
//   game_start      - one-cycle pulse, starts or restarts a session
//   back_to_menu    - one-cycle pulse, abandons to the menu
//   pause_btn       - synchronised button level; each press toggles pause
//   boss_hp         - current boss health
//   current_health  - player health
//   game_state      - encoded state (MENU/ACTIVE/END/PAUSED/LEVEL_CLEAR)
//   game_active     - high only while playing
//   show_menu_end   - high on the menu or end screen
//   level           - 0-based level index
//   level_start     - one-cycle pulse re-initialising boss and character
//   win             - outcome, meaningful on the end screen
//   elapsed_frames  - saturating count of frames played this session
// Every output is a flop; a trigger sampled on one edge shows on the next.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int NUM_LEVELS   = 3,
    parameter int HP_W         = 7,
    parameter int HEALTH_W     = 4,
    parameter int CLEAR_FRAMES = 120,
    parameter int TIME_W       = 16,
    parameter int LVL_W        = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vsync,
    input  logic                game_start,
    input  logic                back_to_menu,
    input  logic                pause_btn,
    input  logic [HP_W-1:0]     boss_hp,
    input  logic [HEALTH_W-1:0] current_health,
    output logic [2:0]          game_state,
    output logic                game_active,
    output logic                show_menu_end,
    output logic [LVL_W-1:0]    level,
    output logic                level_start,
    output logic                win,
    output logic [TIME_W-1:0]   elapsed_frames
);

    localparam int               CNT_W      = $clog2(CLEAR_FRAMES + 1);
    localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_FRAMES);

    logic frame_tick;
    logic pause_edge;

    game_state_t          state_q, state_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 level_start_q, level_start_d;
    logic                 win_q, win_d;
    logic [TIME_W-1:0]    elapsed_q, elapsed_d;
    logic [CNT_W-1:0]     clear_cnt_q, clear_cnt_d;
    logic                 boss_armed_q, boss_armed_d;
    logic                 game_active_q, game_active_d;
    logic                 show_menu_end_q, show_menu_end_d;
    logic                 do_start;
    logic                 boss_kill;
    logic                 player_dead;

    edge_det #(.RISING(1'b1)) u_vsync_edge (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (vsync),
        .edge_out (frame_tick)
    );

    edge_det #(.RISING(1'b1)) u_pause_edge (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (pause_btn),
        .edge_out (pause_edge)
    );

    // Next-state and next-output logic. Within each state the checks run in
    // the global priority order: back_to_menu, death, boss kill, pause,
    // start. A boss kill only counts once the boss has been seen alive in
    // this level, because boss_top needs a few cycles after level_start to
    // reload its HP and would otherwise read as already dead.
    always_comb begin
        state_d         = state_q;
        level_d         = level_q;
        level_start_d   = 1'b0;
        win_d           = win_q;
        elapsed_d       = elapsed_q;
        clear_cnt_d     = clear_cnt_q;
        boss_armed_d    = boss_armed_q;
        do_start        = 1'b0;
        boss_kill       = boss_armed_q && (boss_hp == '0);
        player_dead     = (current_health == '0);

        case (state_q)
            MENU: begin
                if (!back_to_menu && game_start) begin
                    do_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (frame_tick && (elapsed_q != '1)) begin
                    elapsed_d = elapsed_q + TIME_W'(1);
                end
                if (boss_hp != '0) begin
                    boss_armed_d = 1'b1;
                end
                if (back_to_menu) begin
                    state_d = MENU;
                end else if (player_dead) begin
                    state_d = END;
                    win_d   = 1'b0;
                end else if (boss_kill) begin
                    if (level_q == LAST_LEVEL) begin
                        state_d = END;
                        win_d   = 1'b1;
                    end else begin
                        state_d     = LEVEL_CLEAR;
                        clear_cnt_d = CLEAR_LOAD;
                    end
                end else if (pause_edge) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (back_to_menu) begin
                    state_d = MENU;
                end else if (pause_edge) begin
                    state_d = ACTIVE;
                end
            end
            LEVEL_CLEAR: begin
                if (back_to_menu) begin
                    state_d = MENU;
                end else if (frame_tick) begin
                    if ((clear_cnt_q == '0) || (clear_cnt_q == CNT_W'(1))) begin
                        state_d       = ACTIVE;
                        level_d       = level_q + LVL_W'(1);
                        level_start_d = 1'b1;
                        boss_armed_d  = 1'b0;
                        clear_cnt_d   = '0;
                    end else begin
                        clear_cnt_d = clear_cnt_q - CNT_W'(1);
                    end
                end
            end
            END: begin
                if (back_to_menu) begin
                    state_d = MENU;
                end else if (game_start) begin
                    do_start = 1'b1;
                end
            end
            default: begin
                state_d = MENU;
            end
        endcase

        if (do_start) begin
            state_d       = ACTIVE;
            level_d       = '0;
            elapsed_d     = '0;
            win_d         = 1'b0;
            level_start_d = 1'b1;
            boss_armed_d  = 1'b0;
        end

        game_active_d   = (state_d == ACTIVE);
        show_menu_end_d = (state_d == MENU) || (state_d == END);
    end

    // State and output registers. Reset looks exactly like power-up, so a
    // mid-session reset lands on the menu without a level_start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= MENU;
            level_q         <= '0;
            level_start_q   <= 1'b0;
            win_q           <= 1'b0;
            elapsed_q       <= '0;
            clear_cnt_q     <= '0;
            boss_armed_q    <= 1'b0;
            game_active_q   <= 1'b0;
            show_menu_end_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            level_q         <= level_d;
            level_start_q   <= level_start_d;
            win_q           <= win_d;
            elapsed_q       <= elapsed_d;
            clear_cnt_q     <= clear_cnt_d;
            boss_armed_q    <= boss_armed_d;
            game_active_q   <= game_active_d;
            show_menu_end_q <= show_menu_end_d;
        end
    end

    assign game_state     = state_q;
    assign game_active    = game_active_q;
    assign show_menu_end  = show_menu_end_q;
    assign level          = level_q;
    assign level_start    = level_start_q;
    assign win            = win_q;
    assign elapsed_frames = elapsed_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed bench for game_flow_ctrl with a scoreboard.
// The stimulus thread pushes the expected output tuple for every change it
// provokes; a monitor pops and compares whenever the visible outputs
// (state, flags, level, level_start, win) change. Unexpected changes pop an
// empty queue and are reported. DUT built with 3 levels, 4 clear frames and
// a 4-bit frame counter so saturation is reachable.
module tb_game_flow_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] lvl;
        logic       ls;
        logic       win;
        logic [3:0] el;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       vsync;
    logic       game_start;
    logic       back_to_menu;
    logic       pause_btn;
    logic [6:0] boss_hp;
    logic [3:0] current_health;
    logic [2:0] game_state;
    logic       game_active;
    logic       show_menu_end;
    logic [1:0] level;
    logic       level_start;
    logic       win;
    logic [3:0] elapsed_frames;

    exp_t       exp_q[$];
    int         checks = 0;
    int         passes = 0;
    int         event_no = 0;
    logic [8:0] last_snap;
    logic [8:0] cur_snap;
    logic [6:0] cur_hp;
    logic [3:0] cur_hl;
    logic       cur_pb;

    game_flow_ctrl #(
        .NUM_LEVELS   (3),
        .HP_W         (7),
        .HEALTH_W     (4),
        .CLEAR_FRAMES (4),
        .TIME_W       (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .vsync          (vsync),
        .game_start     (game_start),
        .back_to_menu   (back_to_menu),
        .pause_btn      (pause_btn),
        .boss_hp        (boss_hp),
        .current_health (current_health),
        .game_state     (game_state),
        .game_active    (game_active),
        .show_menu_end  (show_menu_end),
        .level          (level),
        .level_start    (level_start),
        .win            (win),
        .elapsed_frames (elapsed_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue one expected output tuple.
    task automatic expectOut(input logic [2:0] st, input logic [1:0] lvl,
                             input logic ls, input logic w, input logic [3:0] el);
        exp_t e;
        e.st  = st;
        e.lvl = lvl;
        e.ls  = ls;
        e.win = w;
        e.el  = el;
        exp_q.push_back(e);
    endtask

    // A level begins: ACTIVE with the pulse, then the pulse drops.
    task automatic expectStart(input logic [1:0] lvl, input logic [3:0] el);
        expectOut(3'd1, lvl, 1'b1, 1'b0, el);
        expectOut(3'd1, lvl, 1'b0, 1'b0, el);
    endtask

    // Hold one set of inputs for one clock, changing them on the falling edge.
    task automatic applyStimulus(input logic gs, input logic btm, input logic vs);
        game_start     = gs;
        back_to_menu   = btm;
        vsync          = vs;
        pause_btn      = cur_pb;
        boss_hp        = cur_hp;
        current_health = cur_hl;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_hp(input logic [6:0] hp);
        cur_hp = hp;
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_pause(input logic pb);
        cur_pb = pb;
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic vsync_edges(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Compare one observed output change with the oldest expectation.
    task automatic checkOutput(input logic [8:0] snap, input logic [3:0] el);
        exp_t       e;
        logic [8:0] want;
        checks++;
        event_no++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL event%0d unexpected: got state=%0d level=%0d ls=%0b win=%0b, required no change",
                     event_no, snap[8:6], snap[3:2], snap[1], snap[0]);
            return;
        end
        e    = exp_q.pop_front();
        want = {e.st, (e.st == 3'd1), ((e.st == 3'd0) || (e.st == 3'd2)), e.lvl, e.ls, e.win};
        if ((snap !== want) || (el !== e.el)) begin
            $display("[TB] FAIL event%0d: got state=%0d act=%0b sme=%0b level=%0d ls=%0b win=%0b el=%0d, required state=%0d act=%0b sme=%0b level=%0d ls=%0b win=%0b el=%0d",
                     event_no, snap[8:6], snap[5], snap[4], snap[3:2], snap[1], snap[0], el,
                     want[8:6], want[5], want[4], want[3:2], want[1], want[0], e.el);
        end else begin
            passes++;
        end
    endtask

    // Monitor: any change in the visible tuple is an output event.
    always @(negedge clk) begin
        cur_snap = {game_state, game_active, show_menu_end, level, level_start, win};
        if (cur_snap !== last_snap) begin
            last_snap = cur_snap;
            checkOutput(cur_snap, elapsed_frames);
        end
    end

    initial begin
        rst    = 1'b1;
        cur_hp = 7'd0;
        cur_hl = 4'd5;
        cur_pb = 1'b0;
        expectOut(3'd0, 2'd0, 1'b0, 1'b0, 4'd0);
        idle(2);
        rst = 1'b0;

        // Start with boss_hp=0: no kill while the boss is unarmed.
        expectStart(2'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(5);

        // Level 0 kill, intermission, level 1 with 3 frames, kill, level 2, win.
        set_hp(7'd50);
        expectOut(3'd4, 2'd0, 1'b0, 1'b0, 4'd0);
        set_hp(7'd0);
        expectStart(2'd1, 4'd0);
        vsync_edges(4);
        vsync_edges(3);
        set_hp(7'd50);
        expectOut(3'd4, 2'd1, 1'b0, 1'b0, 4'd3);
        set_hp(7'd0);
        expectStart(2'd2, 4'd3);
        vsync_edges(4);
        set_hp(7'd50);
        expectOut(3'd2, 2'd2, 1'b0, 1'b1, 4'd3);
        set_hp(7'd0);

        // Restart from END; death and armed kill together lose.
        expectStart(2'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        set_hp(7'd50);
        expectOut(3'd2, 2'd0, 1'b0, 1'b0, 4'd0);
        cur_hl = 4'd0;
        set_hp(7'd0);
        cur_hl = 4'd5;

        // Pause: frames and health ignored while paused, second press resumes.
        expectStart(2'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        vsync_edges(2);
        expectOut(3'd3, 2'd0, 1'b0, 1'b0, 4'd2);
        set_pause(1'b1);
        idle(1);
        cur_hl = 4'd0;
        vsync_edges(10);
        cur_hl = 4'd5;
        set_pause(1'b0);
        idle(2);
        expectOut(3'd1, 2'd0, 1'b0, 1'b0, 4'd2);
        set_pause(1'b1);
        idle(2);
        set_pause(1'b0);

        // back_to_menu from ACTIVE; start+back in MENU stays; back from LEVEL_CLEAR.
        expectOut(3'd0, 2'd0, 1'b0, 1'b0, 4'd2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        idle(3);
        expectStart(2'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        set_hp(7'd50);
        expectOut(3'd4, 2'd0, 1'b0, 1'b0, 4'd0);
        set_hp(7'd0);
        set_pause(1'b1);
        set_pause(1'b0);
        idle(2);
        vsync_edges(2);
        expectOut(3'd0, 2'd0, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(2);

        // 20 frames into a 4-bit counter saturate at 15.
        expectStart(2'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        vsync_edges(20);
        expectOut(3'd0, 2'd0, 1'b0, 1'b0, 4'd15);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(2);

        // Reset during LEVEL_CLEAR at level 1: back to power-up, no pulse.
        expectStart(2'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        set_hp(7'd50);
        expectOut(3'd4, 2'd0, 1'b0, 1'b0, 4'd0);
        set_hp(7'd0);
        expectStart(2'd1, 4'd0);
        vsync_edges(4);
        set_hp(7'd50);
        expectOut(3'd4, 2'd1, 1'b0, 1'b0, 4'd0);
        set_hp(7'd0);
        idle(2);
        expectOut(3'd0, 2'd0, 1'b0, 1'b0, 4'd0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(6);

        checks++;
        if (exp_q.size() != 0) begin
            $display("[TB] FAIL pending: got %0d expected events never seen, required 0", exp_q.size());
        end else begin
            passes++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
